// File: rtl/aes_inv_cipher_core_if.sv
// rtl/aes_inv_cipher_core_if.sv - request, round-key fetch and result signals of the AES-128 inverse cipher core
interface aes_inv_cipher_core_if;
  logic         start;
  logic [127:0] ct_in;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         busy;
  logic         done;
  logic [127:0] pt_out;

  modport master (
    output start, ct_in, rk_data,
    input  rk_addr, busy, done, pt_out
  );

  modport slave (
    input  start, ct_in, rk_data,
    output rk_addr, busy, done, pt_out
  );
endinterface

// File: rtl/aes_inv_cipher_core.sv
// rtl/aes_inv_cipher_core.sv - iterative AES-128 inverse cipher, one inverse round per clock
module aes_inv_cipher_core (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_cipher_core_if.slave bus
);

  // Entry x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] off;
    off = 11'd2040 - {x, 3'b000};
    return INV_SBOX[off +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // 0E*p ^ 0B*q ^ 0D*s ^ 09*t, every product built from one shared xtime chain per byte
  function automatic logic [7:0] inv_mix_byte(input logic [7:0] p, input logic [7:0] q,
                                              input logic [7:0] s, input logic [7:0] t);
    logic [7:0] p2, p4, p8, q2, q4, q8, s2, s4, s8, t2, t4, t8;
    p2 = xtime(p); p4 = xtime(p2); p8 = xtime(p4);
    q2 = xtime(q); q4 = xtime(q2); q8 = xtime(q4);
    s2 = xtime(s); s4 = xtime(s2); s8 = xtime(s4);
    t2 = xtime(t); t4 = xtime(t2); t8 = xtime(t4);
    return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (s8 ^ s4 ^ s) ^ (t8 ^ t);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {inv_mix_byte(a0, a1, a2, a3), inv_mix_byte(a1, a2, a3, a0),
            inv_mix_byte(a2, a3, a0, a1), inv_mix_byte(a3, a0, a1, a2)};
  endfunction

  typedef enum logic [2:0] {IDLE, PREF, ADD, ROUND, FINAL} state_t;

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   r_q, r_d;
  logic [3:0]   addr_q, addr_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] imc;

  // Byte (row i, col c) sits at bits [127-8*(4c+i) -: 8]; row i takes its byte from column c-i.
  genvar gc, gi;
  generate
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gi = 0; gi < 4; gi++) begin : g_row
        assign isr[127-8*(4*gc+gi) -: 8] = st_q[127-8*(4*((gc-gi+4)%4)+gi) -: 8];
        assign isb[127-8*(4*gc+gi) -: 8] = inv_sbox(isr[127-8*(4*gc+gi) -: 8]);
      end
      assign imc[127-32*gc -: 32] = inv_mix_col(ark[127-32*gc -: 32]);
    end
  endgenerate

  assign ark = isb ^ bus.rk_data;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    pt_d    = pt_q;
    r_d     = r_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          st_d    = bus.ct_in;
          addr_d  = 4'd10;
          busy_d  = 1'b1;
          state_d = PREF;
        end
      end
      PREF: begin
        addr_d  = 4'd9;
        state_d = ADD;
      end
      ADD: begin
        st_d    = st_q ^ bus.rk_data;
        addr_d  = 4'd8;
        r_d     = 4'd9;
        state_d = ROUND;
      end
      ROUND: begin
        st_d = imc;
        r_d  = r_q - 4'd1;
        // The fetch runs two keys ahead of consumption; the last one needed is rk0.
        if (r_q >= 4'd2) addr_d = r_q - 4'd2;
        if (r_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        pt_d    = ark;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      pt_q    <= '0;
      r_q     <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      r_q     <= r_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rk_addr = addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pt_out  = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// tb/tb_aes_inv_cipher_core.sv - self-checking bench for aes_inv_cipher_core against an AES-128 reference model
module tb_aes_inv_cipher_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_cipher_core_if bus ();

  aes_inv_cipher_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Round-key memory with one cycle of read latency.
  logic [127:0] rk_mem [11];
  always @(posedge clk) bus.rk_data <= rk_mem[bus.rk_addr];

  logic [7:0] sbox [256];
  int total = 0;
  int bad   = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_mem[0];
    for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk_mem[r];
    return shift_rows(sub_bytes(s)) ^ rk_mem[10];
  endfunction

  // Issues start at the current negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [127:0] ct, input logic [127:0] exp, input bit detail, input int poke_k);
    logic [3:0] addr_seq [16];
    int done_k, busy_n;
    done_k = -1;
    busy_n = 0;
    bus.start = 1'b1;
    bus.ct_in = ct;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (poke_k >= 0 && k == poke_k) begin
        bus.start = 1'b1;
        bus.ct_in = ~ct;
      end
      if (poke_k >= 0 && k == poke_k + 1) begin
        bus.start = 1'b0;
        bus.ct_in = ct;
      end
      addr_seq[k] = bus.rk_addr;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_k = k;
        break;
      end
    end
    check("done_latency", 128'(done_k), 128'd12);
    check("pt_out", bus.pt_out, exp);
    if (detail) begin
      for (int k = 0; k <= 10; k++)
        check($sformatf("rk_addr_E%0d", k), 128'(addr_seq[k]), 128'(10 - k));
      check("busy_cycles", 128'(busy_n), 128'd12);
    end
  endtask

  initial begin
    logic [127:0] key, pt, ct;
    int extra;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.ct_in = '0;
    build_sbox();
    key_expand(C1_KEY);
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_pt_out", bus.pt_out, 128'd0);
    check("rst_rk_addr", 128'(bus.rk_addr), 128'd0);
    check("model_rk10", rk_mem[10], C1_RK10);
    check("model_encrypt", encrypt(C1_PT), C1_CT);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 with full fetch/busy timing
    run_op(C1_CT, C1_PT, 1'b1, -1);
    @(negedge clk);
    check("done_width", 128'(bus.done), 128'd0);
    check("rk_addr_hold", 128'(bus.rk_addr), 128'd0);
    check("pt_hold", bus.pt_out, C1_PT);

    // start with a different ciphertext sampled at E5 is ignored
    run_op(C1_CT, C1_PT, 1'b0, 4);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("busy_start_no_extra_done", 128'(extra), 128'd0);

    // reset asserted at E7 clears everything at once and suppresses done
    bus.start = 1'b1;
    bus.ct_in = C1_CT;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", 128'(bus.busy), 128'd0);
    check("midrst_done", 128'(bus.done), 128'd0);
    check("midrst_pt_out", bus.pt_out, 128'd0);
    check("midrst_rk_addr", 128'(bus.rk_addr), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("midrst_no_done", 128'(extra), 128'd0);
    run_op(C1_CT, C1_PT, 1'b0, -1);

    // back-to-back: start in the done cycle
    run_op(C1_CT, C1_PT, 1'b0, -1);
    @(negedge clk);
    check("b2b_done_width", 128'(bus.done), 128'd0);

    // round trip through the reference encryption
    for (int n = 0; n < 100; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key_expand(key);
      ct = encrypt(pt);
      run_op(ct, pt, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
